// File: rtl/sdram_host_if.sv
// Host-side request front end for the SDRAM command sequencer: latches one
// read/write request, drives rd/wr enables, and steers write data and read capture.
// Define SDRAM_HOST_IF_REQ_QUEUE_EN to add a second (queued) request slot.
module sdram_host_if #(
  parameter int DATA_W = 16,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [BANK_W+ROW_W+COL_W-1:0] host_addr,
  input  logic [DATA_W-1:0]             host_wr_data,
  input  logic                          host_rd_req,
  input  logic                          host_wr_req,
  output logic                          host_busy,
  output logic [DATA_W-1:0]             host_rd_data,
  output logic                          host_rd_valid,
  input  logic [4:0]                    state,
  output logic                          rd_enable,
  output logic                          wr_enable,
  output logic [9:0]                    refresh_cnt,
  output logic [BANK_W-1:0]             sd_bank,
  output logic [ROW_W-1:0]              sd_row,
  output logic [COL_W-1:0]              sd_col,
  output logic [DATA_W-1:0]             sd_dq_out,
  output logic                          sd_dq_oe,
  input  logic [DATA_W-1:0]             sd_dq_in
);

  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  localparam logic [4:0] ST_IDLE       = 5'b00000;
  localparam logic [4:0] ST_REFRESH    = 5'b00001;
  localparam logic [4:0] ST_RD_START   = 5'b10000;
  localparam logic [4:0] ST_RD_CAPTURE = 5'b10100;
  localparam logic [4:0] ST_WR_START   = 5'b11000;
  localparam logic [4:0] ST_WR_DATA    = 5'b11010;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } fsm_e;

  fsm_e                r_fsm;
  fsm_e                w_fsm_nxt;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic [9:0]          r_refresh_cnt;

  logic                w_take_main;
  logic                w_promote;
  logic                w_src_wr;
  logic [ADDR_W-1:0]   w_src_addr;
  logic [DATA_W-1:0]   w_src_data;
  logic                w_start;
  logic                w_done;
  logic                w_capture;
  logic                w_refresh_clr;
  logic                w_busy;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_oe;

  assign w_start   = (r_fsm == PEND) && (state == (r_op_wr ? ST_WR_START : ST_RD_START));
  assign w_done    = (r_fsm == ACTIVE) && (state == ST_IDLE);
  assign w_capture = (r_fsm == ACTIVE) && !r_op_wr && (state == ST_RD_CAPTURE);

`ifdef SDRAM_HOST_IF_REQ_QUEUE_EN
  logic              r_q_valid;
  logic              r_q_wr;
  logic [ADDR_W-1:0] r_q_addr;
  logic [DATA_W-1:0] r_q_data;
  logic              w_req;
  logic              w_take_q;

  // A new request goes straight to the main slot only when nothing older is waiting.
  assign w_req       = host_rd_req | host_wr_req;
  assign w_promote   = w_done & r_q_valid;
  assign w_take_main = w_req & ~r_q_valid & ((r_fsm == FREE) | w_done);
  assign w_take_q    = w_req & ~r_q_valid & ~w_take_main;
  assign w_src_wr    = w_promote ? r_q_wr   : (host_wr_req & ~host_rd_req);
  assign w_src_addr  = w_promote ? r_q_addr : host_addr;
  assign w_src_data  = w_promote ? r_q_data : host_wr_data;
  assign w_busy      = r_q_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_q_valid <= 1'b0;
      r_q_wr    <= 1'b0;
      r_q_addr  <= '0;
      r_q_data  <= '0;
    end else if (w_take_q) begin
      r_q_valid <= 1'b1;
      r_q_wr    <= host_wr_req & ~host_rd_req;
      r_q_addr  <= host_addr;
      r_q_data  <= host_wr_data;
    end else if (w_promote) begin
      r_q_valid <= 1'b0;
    end
  end
`else
  assign w_take_main = (host_rd_req | host_wr_req) & (r_fsm == FREE);
  assign w_promote   = 1'b0;
  assign w_src_wr    = host_wr_req & ~host_rd_req;
  assign w_src_addr  = host_addr;
  assign w_src_data  = host_wr_data;
  assign w_busy      = (r_fsm != FREE);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_fsm <= FREE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_rd_en   = 1'b0;
    w_wr_en   = 1'b0;
    w_oe      = 1'b0;
    case (r_fsm)
      FREE: begin
        if (w_take_main) w_fsm_nxt = PEND;
      end
      PEND: begin
        // Enable stays up through any refresh until our own sequence starts.
        w_rd_en = !r_op_wr;
        w_wr_en = r_op_wr;
        if (w_start) w_fsm_nxt = ACTIVE;
      end
      ACTIVE: begin
        w_oe = r_op_wr && (state == ST_WR_DATA);
        if (w_done) w_fsm_nxt = (w_promote | w_take_main) ? PEND : FREE;
      end
      default: w_fsm_nxt = FREE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else if (w_take_main | w_promote) begin
      r_op_wr   <= w_src_wr;
      r_addr    <= w_src_addr;
      r_wr_data <= w_src_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_capture;
      if (w_capture) r_rd_data <= sd_dq_in;
    end
  end

  // Any refresh or init activity restarts the interval count.
  assign w_refresh_clr = (state == ST_REFRESH) || (state[4:3] == 2'b01);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_refresh_cnt <= '0;
    end else if (w_refresh_clr) begin
      r_refresh_cnt <= '0;
    end else if (r_refresh_cnt != 10'd1023) begin
      r_refresh_cnt <= r_refresh_cnt + 10'd1;
    end
  end

  assign host_busy     = w_busy;
  assign host_rd_data  = r_rd_data;
  assign host_rd_valid = r_rd_valid;
  assign rd_enable     = w_rd_en;
  assign wr_enable     = w_wr_en;
  assign refresh_cnt   = r_refresh_cnt;
  assign sd_bank       = r_addr[ADDR_W-1 -: BANK_W];
  assign sd_row        = r_addr[COL_W +: ROW_W];
  assign sd_col        = r_addr[COL_W-1:0];
  assign sd_dq_oe      = w_oe;
  assign sd_dq_out     = w_oe ? r_wr_data : '0;

endmodule

// File: tb/tb_sdram_host_if.sv
// Directed bench for sdram_host_if with a hand-stepped sequencer state.
module tb_sdram_host_if;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [23:0] host_addr;
  logic [15:0] host_wr_data;
  logic        host_rd_req;
  logic        host_wr_req;
  logic        host_busy;
  logic [15:0] host_rd_data;
  logic        host_rd_valid;
  logic [4:0]  state;
  logic        rd_enable;
  logic        wr_enable;
  logic [9:0]  refresh_cnt;
  logic [1:0]  sd_bank;
  logic [12:0] sd_row;
  logic [8:0]  sd_col;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [15:0] sd_dq_in;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 CLK = ~CLK;

  sdram_host_if dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .host_addr    (host_addr),
    .host_wr_data (host_wr_data),
    .host_rd_req  (host_rd_req),
    .host_wr_req  (host_wr_req),
    .host_busy    (host_busy),
    .host_rd_data (host_rd_data),
    .host_rd_valid(host_rd_valid),
    .state        (state),
    .rd_enable    (rd_enable),
    .wr_enable    (wr_enable),
    .refresh_cnt  (refresh_cnt),
    .sd_bank      (sd_bank),
    .sd_row       (sd_row),
    .sd_col       (sd_col),
    .sd_dq_out    (sd_dq_out),
    .sd_dq_oe     (sd_dq_oe),
    .sd_dq_in     (sd_dq_in)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount = compareCount + 1;
    if (got !== exp) begin
      mismatchCount = mismatchCount + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [23:0] addr,
                               input logic [15:0] data, input logic [4:0] st, input logic [15:0] dqIn);
    host_rd_req  = rd;
    host_wr_req  = wr;
    host_addr    = addr;
    host_wr_data = data;
    state        = st;
    sd_dq_in     = dqIn;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  logic [4:0] refSeq [5];

  initial begin
    refSeq = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00000};
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    repeat (2) nextCycle();
    @(negedge CLK);
    checkOutput("busyReset",    32'(host_busy),     32'd0);
    checkOutput("rdEnReset",    32'(rd_enable),     32'd0);
    checkOutput("wrEnReset",    32'(wr_enable),     32'd0);
    checkOutput("oeReset",      32'(sd_dq_oe),      32'd0);
    checkOutput("rdValidReset", 32'(host_rd_valid), 32'd0);
    checkOutput("rdDataReset",  32'(host_rd_data),  32'd0);
    checkOutput("refCntReset",  32'(refresh_cnt),   32'd0);
    nextCycle();
    RESET = 1'b1;
    nextCycle();
    @(negedge CLK);
    checkOutput("refCntFirst", 32'(refresh_cnt), 32'd1);

    // Write 24'h40_1234 -> bank 1, row 9, col 52
    nextCycle(); applyStimulus(1'b0, 1'b1, 24'h40_1234, 16'hBEEF, 5'b00000, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("wrEnAccept", 32'(wr_enable), 32'd1);
    checkOutput("busyAccept", 32'(host_busy), 32'd1);
    checkOutput("rdEnOnWr",   32'(rd_enable), 32'd0);
    checkOutput("bankWr",     32'(sd_bank),   32'd1);
    checkOutput("rowWr",      32'(sd_row),    32'd9);
    checkOutput("colWr",      32'(sd_col),    32'd52);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11000, 16'h0);
    @(negedge CLK);
    checkOutput("wrEnAt11000", 32'(wr_enable), 32'd1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11001, 16'h0);
    @(negedge CLK);
    checkOutput("wrEnDrop", 32'(wr_enable), 32'd0);
    checkOutput("oe11001",  32'(sd_dq_oe),  32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11010, 16'h0);
    @(negedge CLK);
    checkOutput("oe11010",    32'(sd_dq_oe),  32'd1);
    checkOutput("dqOut11010", 32'(sd_dq_out), 32'hBEEF);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11011, 16'h0);
    @(negedge CLK);
    checkOutput("oe11011", 32'(sd_dq_oe), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("busyAtIdle", 32'(host_busy), 32'd1);
    nextCycle();
    @(negedge CLK);
    checkOutput("busyWrDone", 32'(host_busy), 32'd0);
    checkOutput("bankHold",   32'(sd_bank),   32'd1);

    // Read 24'h81_0005 -> bank 2, row 128, col 5
    nextCycle(); applyStimulus(1'b1, 1'b0, 24'h81_0005, 16'h0, 5'b00000, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10000, 16'h0);
    @(negedge CLK);
    checkOutput("rdEnAccept", 32'(rd_enable), 32'd1);
    checkOutput("bankRd",     32'(sd_bank),   32'd2);
    checkOutput("rowRd",      32'(sd_row),    32'd128);
    checkOutput("colRd",      32'(sd_col),    32'd5);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10001, 16'h0);
    @(negedge CLK);
    checkOutput("rdEnDrop", 32'(rd_enable), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10010, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10011, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10100, 16'hA5A5);
    @(negedge CLK);
    checkOutput("rdValidEarly", 32'(host_rd_valid), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("rdValid", 32'(host_rd_valid), 32'd1);
    checkOutput("rdData",  32'(host_rd_data),  32'hA5A5);
    nextCycle();
    @(negedge CLK);
    checkOutput("rdValidPulse", 32'(host_rd_valid), 32'd0);
    checkOutput("rdDataHold",   32'(host_rd_data),  32'hA5A5);
    checkOutput("busyRdDone",   32'(host_busy),     32'd0);

    // Simultaneous rd/wr: read wins; then a refresh preempts the pending read
    nextCycle(); applyStimulus(1'b1, 1'b1, 24'hC0_0010, 16'h1111, 5'b00000, 16'h0);
`ifdef SDRAM_HOST_IF_REQ_QUEUE_EN
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
`else
    nextCycle(); applyStimulus(1'b0, 1'b1, 24'h00_0001, 16'h2222, 5'b00000, 16'h0);
`endif
    @(negedge CLK);
    checkOutput("rdEnBoth", 32'(rd_enable), 32'd1);
    checkOutput("wrEnBoth", 32'(wr_enable), 32'd0);
    for (int i = 0; i < 5; i++) begin
      nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, refSeq[i], 16'h0);
      @(negedge CLK);
      checkOutput("rdEnRefresh", 32'(rd_enable), 32'd1);
      if (i == 1) checkOutput("refCntInRefresh", 32'(refresh_cnt), 32'd0);
    end
    checkOutput("bankBoth", 32'(sd_bank), 32'd3);
    checkOutput("colBoth",  32'(sd_col),  32'd16);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10000, 16'h0);
    @(negedge CLK);
    checkOutput("rdEnAfterRef", 32'(rd_enable), 32'd1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10001, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10010, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10011, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b10100, 16'h1234);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("rdValidRef", 32'(host_rd_valid), 32'd1);
    checkOutput("rdDataRef",  32'(host_rd_data),  32'h1234);
    nextCycle();
    nextCycle();
    @(negedge CLK);
    checkOutput("busyAfterBoth", 32'(host_busy), 32'd0);
    checkOutput("wrDropped",     32'(wr_enable), 32'd0);

    // refresh_cnt saturation and clearing
    repeat (1100) nextCycle();
    @(negedge CLK);
    checkOutput("refCntSat", 32'(refresh_cnt), 32'd1023);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00001, 16'h0);
    @(negedge CLK);
    checkOutput("refCntSatHold", 32'(refresh_cnt), 32'd1023);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("refCntClear", 32'(refresh_cnt), 32'd0);
    nextCycle();
    @(negedge CLK);
    checkOutput("refCntRestart", 32'(refresh_cnt), 32'd1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b01010, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("refCntInitClr", 32'(refresh_cnt), 32'd0);

    // Reset asserted mid-write while state shows the data phase
    nextCycle(); applyStimulus(1'b0, 1'b1, 24'h40_0100, 16'h5A5A, 5'b00000, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11000, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11001, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11010, 16'h0);
    @(negedge CLK);
    checkOutput("oeBeforeRst", 32'(sd_dq_oe), 32'd1);
    #1 RESET = 1'b0;
    #1;
    checkOutput("oeMidRst",     32'(sd_dq_oe),    32'd0);
    checkOutput("busyMidRst",   32'(host_busy),   32'd0);
    checkOutput("refCntMidRst", 32'(refresh_cnt), 32'd0);
    checkOutput("bankMidRst",   32'(sd_bank),     32'd0);
    checkOutput("dqOutMidRst",  32'(sd_dq_out),   32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    RESET = 1'b1;
    nextCycle();
    @(negedge CLK);
    checkOutput("wrEnAfterRst", 32'(wr_enable), 32'd0);

`ifdef SDRAM_HOST_IF_REQ_QUEUE_EN
    // Two back-to-back writes: second is queued and serviced after the first
    nextCycle(); applyStimulus(1'b0, 1'b1, 24'h40_0000, 16'h0A0A, 5'b00000, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b1, 24'h80_0000, 16'h0B0B, 5'b00000, 16'h0);
    @(negedge CLK);
    checkOutput("qBusyOneSlot", 32'(host_busy), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11000, 16'h0);
    @(negedge CLK);
    checkOutput("qBusyFull", 32'(host_busy), 32'd1);
    checkOutput("qBankA",    32'(sd_bank),   32'd1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11001, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11010, 16'h0);
    @(negedge CLK);
    checkOutput("qDqA", 32'(sd_dq_out), 32'h0A0A);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b11011, 16'h0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 5'b00000, 16'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("qWrEnB", 32'(wr_enable), 32'd1);
    checkOutput("qBankB", 32'(sd_bank),   32'd2);
    checkOutput("qBusyB", 32'(host_busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
